// File: rtl/mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// mem_access_sequencer
//
// Purpose:
//   Control stage that sits directly in front of the memory address manager.
//   A single start request (base address, word count, read/write op) becomes
//   the following sequence:
//     - one LOAD cycle that presents the base address with both enables low,
//       so the manager preloads it;
//     - one read or write enable per word after that.
//   The sequencer keeps its own copy of the current address (base + count).
//   Because of this, stalls and aborts never lose the manager's position.
//
// Ports:
//   clk          in   single clock, all state updates on posedge
//   rst          in   synchronous active-high reset
//   start        in   request pulse, accepted only when idle
//   op_write     in   0 = read burst, 1 = write burst (sampled with start)
//   base_addr    in   first word address (sampled with start)
//   length       in   word count, 0 is legal (sampled with start)
//   hold         in   stall, suppresses the enable in the same cycle
//   abort        in   terminates an active burst
//   read_enable  out  read strobe to the address manager
//   write_enable out  write strobe to the address manager
//   mem_address  out  address to the manager's input_address
//   busy         out  high while loading or running a burst
//   done         out  one-cycle pulse at burst end (normal or aborted)
//   aborted      out  last burst ended by abort, cleared on next start
//   words_done   out  accesses issued in the current/last burst
// ---------------------------------------------------------------------------
module mem_access_sequencer #(
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_write,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              hold,
    input  logic              abort,
    output logic              read_enable,
    output logic              write_enable,
    output logic [ADDR_W-1:0] mem_address,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] words_done
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              op;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] count;

    // An access is issued only in RUN when neither stall nor abort is present.
    // Abort wins over hold: both suppress the strobe, but only abort ends
    // the burst.
    logic access_now;
    logic last_word;

    assign access_now = (state == RUN) && !hold && !abort;
    assign last_word  = (count == (len - ONE));

    // State register: reset always returns to IDLE. No done pulse is
    // produced on reset because DONE is only reached through the
    // next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero-length request goes straight to DONE so that
    // no enables are issued and busy never rises.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                state_next = abort ? DONE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_next = DONE;
                end else if (!hold && last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Burst bookkeeping. Request fields are latched only on an accepted
    // start, so starts that arrive while busy or in DONE cannot disturb
    // the running burst. When an abort arrives, count keeps the number of
    // accesses already issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            op      <= 1'b0;
            base    <= '0;
            len     <= '0;
            count   <= '0;
            aborted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op      <= op_write;
                        base    <= base_addr;
                        len     <= length;
                        count   <= '0;
                        aborted <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (access_now) begin
                        count <= count + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The address is always base + count, wrapping naturally at the register
    // width. In LOAD, count is zero, so the manager sees the base. During a
    // hold, or outside RUN, the value is stable, so a manager reload leaves
    // its position unchanged.
    assign mem_address = base + count;
    assign words_done  = count;

    // Output decode. The enables are gated combinationally by hold/abort,
    // so a stall or abort takes effect in the same cycle. They are mutually
    // exclusive through op.
    always_comb begin
        read_enable  = 1'b0;
        write_enable = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            LOAD: begin
                busy = 1'b1;
            end
            RUN: begin
                busy         = 1'b1;
                read_enable  = access_now && !op;
                write_enable = access_now && op;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_access_sequencer
//
// Purpose:
//   Directed bench for mem_access_sequencer. A burst-level reference model
//   (remaining-word countdown plus phase flags) predicts every output.
//   That prediction is compared on each negedge. Directed sequences also
//   pin the model with hand-computed literal values taken from the burst
//   timing: load in cycle 1, words in cycles 2..N+1, done in cycle N+2.
// ---------------------------------------------------------------------------
module tb_mem_access_sequencer;

    localparam int ADDR_W = 19;

    logic              clk;
    logic              rst;
    logic              start;
    logic              op_write;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              hold;
    logic              abort;
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] mem_address;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W-1:0] words_done;

    int vectors    = 0;
    int miscompares = 0;

    mem_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_write    (op_write),
        .base_addr   (base_addr),
        .length      (length),
        .hold        (hold),
        .abort       (abort),
        .read_enable (read_enable),
        .write_enable(write_enable),
        .mem_address (mem_address),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .words_done  (words_done)
    );

    // Clock with period 10. Posedges fall at 5, 15, and so on.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Burst-level reference model. A burst is described by its phase flags,
    // the words still to issue, and the words already issued. The address
    // is simply where the next word would go.
    logic              model_valid = 1'b0;
    logic              m_loading   = 1'b0;
    logic              m_running   = 1'b0;
    logic              m_ending    = 1'b0;
    logic              m_write     = 1'b0;
    logic              m_aborted   = 1'b0;
    logic [ADDR_W-1:0] m_base      = '0;
    logic [ADDR_W-1:0] m_issued    = '0;
    logic [ADDR_W-1:0] m_left      = '0;

    always @(posedge clk) begin
        if (rst) begin
            model_valid <= 1'b1;
            m_loading   <= 1'b0;
            m_running   <= 1'b0;
            m_ending    <= 1'b0;
            m_write     <= 1'b0;
            m_aborted   <= 1'b0;
            m_base      <= '0;
            m_issued    <= '0;
            m_left      <= '0;
        end else if (!m_loading && !m_running && !m_ending) begin
            if (start) begin
                m_write   <= op_write;
                m_base    <= base_addr;
                m_issued  <= '0;
                m_left    <= length;
                m_aborted <= 1'b0;
                if (length == '0) m_ending  <= 1'b1;
                else              m_loading <= 1'b1;
            end
        end else if (m_loading) begin
            m_loading <= 1'b0;
            if (abort) begin
                m_aborted <= 1'b1;
                m_ending  <= 1'b1;
            end else begin
                m_running <= 1'b1;
            end
        end else if (m_running) begin
            if (abort) begin
                m_aborted <= 1'b1;
                m_running <= 1'b0;
                m_ending  <= 1'b1;
            end else if (!hold) begin
                m_issued <= m_issued + 1'b1;
                m_left   <= m_left - 1'b1;
                if (m_left == 1) begin
                    m_running <= 1'b0;
                    m_ending  <= 1'b1;
                end
            end
        end else begin
            m_ending <= 1'b0;
        end
    end

    // Single comparison routine. It counts each vector and reports any
    // difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     name, $time, actual, expected);
        end
    endtask

    // Per-cycle compare against the model on every negedge once reset has
    // been seen. The enables are computed here from the live hold/abort
    // inputs.
    always @(negedge clk) begin
        if (model_valid) begin
            logic [ADDR_W-1:0] exp_addr;
            logic              strobe;
            exp_addr = m_base + m_issued;
            strobe   = m_running && !hold && !abort;
            checkOutput("model.read_enable",  32'(read_enable),  32'(strobe && !m_write));
            checkOutput("model.write_enable", 32'(write_enable), 32'(strobe && m_write));
            checkOutput("model.mem_address",  32'(mem_address),  32'(exp_addr));
            checkOutput("model.busy",         32'(busy),         32'(m_loading || m_running));
            checkOutput("model.done",         32'(done),         32'(m_ending));
            checkOutput("model.aborted",      32'(aborted),      32'(m_aborted));
            checkOutput("model.words_done",   32'(words_done),   32'(m_issued));
        end
    end

    // Drives one cycle's inputs at posedge+1. It then settles to posedge+4,
    // so that literal checks read stable combinational outputs.
    task automatic applyStimulus(input logic r, input logic st, input logic opw,
                                 input logic [ADDR_W-1:0] ba,
                                 input logic [ADDR_W-1:0] ln,
                                 input logic hd, input logic ab);
        rst       = r;
        start     = st;
        op_write  = opw;
        base_addr = ba;
        length    = ln;
        hold      = hd;
        abort     = ab;
        #3;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        nextCycle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_write = 1'b0; base_addr = '0;
        length = '0; hold = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("reset.busy",        32'(busy),        32'h0);
        checkOutput("reset.mem_address", 32'(mem_address), 32'h0);
        checkOutput("reset.words_done",  32'(words_done),  32'h0);
        nextCycle();

        // Read burst, no stall: base 0x100, 4 words
        applyStimulus(0, 1, 0, 19'h00100, 19'd4, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("rd.load_busy", 32'(busy),        32'h1);
        checkOutput("rd.load_re",   32'(read_enable), 32'h0);
        checkOutput("rd.load_addr", 32'(mem_address), 32'h00100);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, '0, '0, 0, 0);
            checkOutput("rd.re",   32'(read_enable),  32'h1);
            checkOutput("rd.we",   32'(write_enable), 32'h0);
            checkOutput("rd.addr", 32'(mem_address),  32'h00100 + 32'(i));
            nextCycle();
        end
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("rd.done",  32'(done),       32'h1);
        checkOutput("rd.words", 32'(words_done), 32'd4);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("rd.done_gone", 32'(done), 32'h0);
        nextCycle();

        // Write burst with one hold after the 2nd enable, wrapping the address
        applyStimulus(0, 1, 1, 19'h7FFFE, 19'd4, 0, 0);
        nextCycle();
        idleCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("wr.we1",   32'(write_enable), 32'h1);
        checkOutput("wr.addr1", 32'(mem_address),  32'h7FFFE);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("wr.addr2", 32'(mem_address),  32'h7FFFF);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 1, 0);
        checkOutput("wr.hold_we",   32'(write_enable), 32'h0);
        checkOutput("wr.hold_addr", 32'(mem_address),  32'h00000);
        checkOutput("wr.hold_busy", 32'(busy),         32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("wr.we3",   32'(write_enable), 32'h1);
        checkOutput("wr.addr3", 32'(mem_address),  32'h00000);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("wr.addr4", 32'(mem_address),  32'h00001);
        checkOutput("wr.re4",   32'(read_enable),  32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("wr.done",  32'(done),       32'h1);
        checkOutput("wr.words", 32'(words_done), 32'd4);
        nextCycle();
        idleCycle();

        // Zero length: done in cycle 1, no busy
        applyStimulus(0, 1, 0, 19'h00055, 19'd0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("zero.done",  32'(done),       32'h1);
        checkOutput("zero.busy",  32'(busy),       32'h0);
        checkOutput("zero.re",    32'(read_enable), 32'h0);
        checkOutput("zero.words", 32'(words_done), 32'h0);
        nextCycle();
        idleCycle();

        // Abort in 4th RUN cycle of a 10-word read burst
        applyStimulus(0, 1, 0, 19'h00200, 19'd10, 0, 0);
        nextCycle();
        repeat (4) idleCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 1);
        checkOutput("abt.re_gated", 32'(read_enable), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("abt.done",    32'(done),       32'h1);
        checkOutput("abt.aborted", 32'(aborted),    32'h1);
        checkOutput("abt.words",   32'(words_done), 32'd3);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 1);
        checkOutput("abt.idle_aborted", 32'(aborted), 32'h1);
        nextCycle();

        // New start clears aborted; starts during RUN and DONE are ignored
        applyStimulus(0, 1, 1, 19'h00300, 19'd3, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("sb.aborted_clr", 32'(aborted), 32'h0);
        nextCycle();
        applyStimulus(0, 1, 0, 19'h07000, 19'd9, 0, 0);
        checkOutput("sb.addr_run1", 32'(mem_address), 32'h00300);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("sb.addr_run2", 32'(mem_address),  32'h00301);
        checkOutput("sb.we_run2",   32'(write_enable), 32'h1);
        nextCycle();
        idleCycle();
        applyStimulus(0, 1, 0, 19'h07000, 19'd9, 0, 0);
        checkOutput("sb.done", 32'(done), 32'h1);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("sb.idle_busy", 32'(busy),        32'h0);
        checkOutput("sb.idle_addr", 32'(mem_address), 32'h00303);
        checkOutput("sb.words",     32'(words_done),  32'd3);
        nextCycle();

        // Abort during LOAD: no accesses, aborted set
        applyStimulus(0, 1, 0, 19'h00020, 19'd5, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("ldabt.done",    32'(done),       32'h1);
        checkOutput("ldabt.aborted", 32'(aborted),    32'h1);
        checkOutput("ldabt.words",   32'(words_done), 32'h0);
        nextCycle();
        idleCycle();

        // Reset in the 2nd RUN cycle, then a fresh 2-word read
        applyStimulus(0, 1, 0, 19'h00400, 19'd5, 0, 0);
        nextCycle();
        repeat (2) idleCycle();
        applyStimulus(1, 0, 0, '0, '0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("rst.busy",  32'(busy),        32'h0);
        checkOutput("rst.done",  32'(done),        32'h0);
        checkOutput("rst.addr",  32'(mem_address), 32'h0);
        checkOutput("rst.words", 32'(words_done),  32'h0);
        nextCycle();
        applyStimulus(0, 1, 0, 19'h00010, 19'd2, 0, 0);
        nextCycle();
        idleCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("post.addr0", 32'(mem_address), 32'h00010);
        checkOutput("post.re0",   32'(read_enable), 32'h1);
        nextCycle();
        idleCycle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkOutput("post.done",  32'(done),       32'h1);
        checkOutput("post.words", 32'(words_done), 32'd2);
        nextCycle();
        repeat (2) idleCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Control stage directly upstream of the memory address manager. It turns a single start request (base address, word count, read/write op) into the `read_enable`/`write_enable`/address pattern that manager consumes: one LOAD cycle to preload the base, then one enable per word. It keeps its own copy of the current address so that stalls and aborts never lose the manager's position. Start/busy/done handshake faces the processing datapath.

## Interface
- `ADDR_W`, 19: address and length width. Must match the address manager.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `op_write`  in  1  sampled with accepted `start`: 0 = read burst, 1 = write burst.
- `base_addr`  in  ADDR_W  first word address, sampled with accepted `start`.
- `length`  in  ADDR_W  word count, sampled with accepted `start`; 0 is legal.
- `hold`  in  1  stall; suppresses the enable in the same cycle.
- `abort`  in  1  terminates an active burst.
- `read_enable`  out  1  to the address manager.
- `write_enable`  out  1  to the address manager.
- `mem_address`  out  ADDR_W  to the manager's `input_address`.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  one-cycle pulse at burst end, normal or aborted.
- `aborted`  out  1  high if the last burst ended by abort; cleared on next accepted start.
- `words_done`  out  ADDR_W  accesses issued in the current/last burst; cleared on accepted start.

## Operation
- States are IDLE, LOAD, RUN and DONE. Registers: `op`, `base`, `len`, `count`, `aborted`.
- **Reset:** state IDLE; `count`, `base`, `len`, `op`, `aborted` = 0. All outputs 0 (`mem_address` = 0).
- **IDLE:**
  - `start`=1 with `length`≠0: latch inputs, clear `count`/`aborted`, go to LOAD.
  - `start`=1 with `length`=0: latch inputs, clear `count`/`aborted`, go to DONE with no enables.
  - `abort` is ignored in IDLE.
- **LOAD:** both enables 0 and `mem_address`=`base`, so the manager loads the base. Next state is RUN, or DONE if `abort`=1.
- **RUN:**
  - `mem_address` = (`base`+`count`) mod 2^ADDR_W.
  - Enable: `read_enable` = !`op` & !`hold` & !`abort`; `write_enable` = `op` & !`hold` & !`abort`. Both are combinational on `hold`/`abort`.
  - On an enabled cycle, `count` increments. If `count` = `len`−1, go to DONE.
  - On a `hold` cycle: enables 0 and `count` unchanged. The manager reloads `mem_address`, which equals its current value, so its position is preserved.
  - `abort` (priority over `hold`): enables 0, set `aborted`, go to DONE. `count` keeps the number of accesses already issued.
- **DONE:** `done`=1 for exactly one cycle, enables 0, `start` ignored. Next state is IDLE.
- **Outside RUN:** `mem_address` holds (`base`+`count`) mod 2^ADDR_W, so the manager idles on a stable value.
- **Enables:** `read_enable` and `write_enable` are never high together, and never high outside RUN.
- **Outputs:** `words_done` = `count`. `busy` = (state is LOAD or RUN).
- **Address wrap:** `base`+`count` wraps modulo 2^ADDR_W; no error is flagged. Max `length` = 2^ADDR_W−1.
- **`rst` mid-burst:** returns to IDLE next edge with outputs 0. No `done` pulse is produced.

## Timing
- Accepted `start` sampled at edge E0. LOAD occupies cycle 1. RUN occupies cycles 2..N+1 for `length`=N with no hold. `done` is high in cycle N+2. IDLE from cycle N+3; the earliest next accepted start is sampled at edge N+3.
- Each `hold` cycle in RUN extends the burst by exactly one cycle.
- `length`=0: `done` is high in cycle 1; `busy` never rises.
- `abort` sampled high at edge Ek in LOAD/RUN: the enables are already 0 in the cycle ending at Ek. `done` and `aborted` are high in cycle k+1.
- Enables and `mem_address` are valid before the manager's negedge within each cycle.

## Test plan
- **Read burst, no stall:** reset, then `start` with `base`=0x00100, `length`=4, `op_write`=0. Required: `read_enable` high cycles 2–5; `mem_address` 0x00100, 0x00101, 0x00102, 0x00103; `write_enable` never high; `done` pulse in cycle 6; `words_done`=4.
- **Write burst with hold:** `base`=0x7FFFE, `length`=4, `op_write`=1, `hold` high for one cycle after the 2nd enable. Required: `write_enable` on 4 cycles split 2+2; address sequence 0x7FFFE, 0x7FFFF, (hold at 0x00000), 0x00000, 0x00001 (wrap); `done` in cycle 7.
- **Zero length:** `length`=0. Required: no enables, `busy` stays 0, `done` high in cycle 1, `words_done`=0.
- **Abort mid-burst:** `length`=10, `abort` high in the 4th RUN cycle. Required: exactly 3 enables; `done` and `aborted`=1 the next cycle; `words_done`=3. The next start clears `aborted`.
- **Start while busy / in DONE:** a second `start` during RUN and during DONE is ignored; the latched `base`/`length` are unchanged.
- **Reset mid-RUN:** `rst` in the 2nd RUN cycle. Required: all outputs 0 next cycle, no `done` pulse; a fresh `start` then works normally.
